// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the counter state machine.
// The conditioner uses the slave side; the pin/test driver uses the master side.
interface button_conditioner_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel two-flop synchronizer, counter debouncer and press/release strobes.
// Optional auto-repeat press strobes are built when AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_conditioner_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || (CNT_W < 31 && DEBOUNCE_CYCLES > (1 << CNT_W)) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_conditioner: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1_q, s2_q;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] rpt_fire;
    logic               any_q, any_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];

    // Counter only advances while the synchronized input disagrees with the level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_TERM) begin
                    level_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        release_d = level_q & ~level_d;
        press_d   = (~level_q & level_d) | rpt_fire;
        any_d     = |press_d;
    end

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_TERM = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TERM = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]   rpt_q [NUM_BTN];
    logic [RPT_W-1:0]   rpt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rep_q, rep_d;

    // Held only while the level is 1 before and after this edge, so press and
    // release edges both restart the repeat timing and never fire.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            rpt_d[i]    = rpt_q[i];
            rep_d[i]    = rep_q[i];
            rpt_fire[i] = 1'b0;
            if (!level_q[i] || !level_d[i]) begin
                rpt_d[i] = '0;
                rep_d[i] = 1'b0;
            end else if ((!rep_q[i] && rpt_q[i] == DLY_TERM) ||
                         ( rep_q[i] && rpt_q[i] == PER_TERM)) begin
                rpt_fire[i] = 1'b1;
                rpt_d[i]    = '0;
                rep_d[i]    = 1'b1;
            end else begin
                rpt_d[i] = rpt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) rpt_q[i] <= '0;
        end else begin
            rep_q <= rep_d;
            for (int i = 0; i < NUM_BTN; i++) rpt_q[i] <= rpt_d[i];
        end
    end
`else
    assign rpt_fire = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= bus.btn_raw;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_press   = any_q;

endmodule
